// File: rtl/ysyx_24110015_axi_slave_sram.sv
// AXI4 slave scratchpad: one transaction at a time against a word-addressed SRAM.
// Writes win over reads when both address channels are valid in IDLE.
module ysyx_24110015_axi_slave_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0F00_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awid_i,
  input  logic [7:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  output logic [3:0]  bid_o,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arid_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic [3:0]  rid_o
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] W_DATA = 3'd1;
  localparam logic [2:0] W_RESP = 3'd2;
  localparam logic [2:0] R_READ = 3'd3;
  localparam logic [2:0] R_DATA = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             beat_ok;
  logic             last_beat;
  logic [31:0]      next_addr;
  logic             aw_fire, ar_fire, w_fire;

  assign off       = addr_q - BASE_ADDR;
  assign idx       = off[IDX_W+1:2];
  assign beat_ok   = (size_q == 3'b010) && !burst_q[1] && (addr_q >= BASE_ADDR)
                     && (off < SPAN) && (addr_q[1:0] == 2'b00);
  assign last_beat = (cnt_q == len_q);
  assign next_addr = (burst_q == 2'b01) ? addr_q + 32'd4 : addr_q;

  assign awready_o = (state_q == IDLE) && !rst_i;
  assign arready_o = (state_q == IDLE) && !awvalid_i && !rst_i;
  assign wready_o  = (state_q == W_DATA);
  assign bvalid_o  = (state_q == W_RESP);
  assign bresp_o   = err_q ? 2'b10 : 2'b00;
  assign bid_o     = id_q;
  assign rvalid_o  = (state_q == R_DATA);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;
  assign rid_o     = rid_q;

  assign aw_fire = awvalid_i && awready_o;
  assign ar_fire = arvalid_i && arready_o;
  assign w_fire  = wvalid_i && wready_o;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    rid_d   = rid_q;
    case (state_q)
      IDLE: begin
        if (aw_fire) begin
          state_d = W_DATA;
          addr_d  = awaddr_i;
          id_d    = awid_i;
          len_d   = awlen_i;
          size_d  = awsize_i;
          burst_d = awburst_i;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end else if (ar_fire) begin
          state_d = R_READ;
          addr_d  = araddr_i;
          id_d    = arid_i;
          len_d   = arlen_i;
          size_d  = arsize_i;
          burst_d = arburst_i;
          cnt_d   = 8'd0;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          // A wlast that disagrees with the beat count is an error, but the count still ends the burst.
          if (!beat_ok || (wlast_i != last_beat)) err_d = 1'b1;
          if (last_beat) begin
            state_d = W_RESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end
      W_RESP: begin
        if (bready_i) state_d = IDLE;
      end
      R_READ: begin
        state_d = R_DATA;
        rresp_d = beat_ok ? 2'b00 : 2'b10;
        rlast_d = last_beat;
        rid_d   = id_q;
      end
      R_DATA: begin
        if (rready_i) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            state_d = R_READ;
            cnt_d   = cnt_q + 8'd1;
            addr_d  = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
      rid_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
      rid_q   <= rid_d;
      if (state_q == R_READ) rdata_q <= beat_ok ? mem[idx] : 32'd0;
    end
  end

  // SRAM array: no reset, contents survive rst.
  always_ff @(posedge clk_i) begin
    if (w_fire && beat_ok && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule
